// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide unit owning HI/LO.
// Define MULDIV_SIGNED_EN to compile in signed mult/div selected by op[0].
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             kill,
    input  logic             wrhi,
    input  logic             wrlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic               dz_prev_q, dz_prev_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

`ifdef MULDIV_SIGNED_EN
    logic neg_q, neg_d;
    logic rneg_q, rneg_d;
    logic sa, sb;
    assign sa = op[0] & srca[WIDTH-1];
    assign sb = op[0] & srcb[WIDTH-1];
`else
    logic unused_op;
    assign unused_op = op[0];
`endif

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Datapath for one iteration and the final sign-corrected result
    always_comb begin
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, ma_q};
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], mq_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, mb_q};
        diff   = rem_sh[WIDTH-1:0] - mb_q;
        prod   = acc_q;
        quot   = mq_q;
        rem    = acc_q[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (neg_q) begin
            prod = -acc_q;
            quot = -mq_q;
        end
        if (rneg_q) rem = -acc_q[2*WIDTH-1:WIDTH];
`endif
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (dz_q) begin
                res_hi = a_raw_q;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        dz_prev_d = dz_prev_q;
        a_raw_d   = a_raw_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        mq_d      = mq_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
`ifdef MULDIV_SIGNED_EN
        neg_d     = neg_q;
        rneg_d    = rneg_q;
`endif
        if (wrhi) hi_d = wdata;
        if (wrlo) lo_d = wdata;

        if (kill && state_q != IDLE) begin
            state_d   = IDLE;
            divzero_d = dz_prev_q;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !kill) begin
                        state_d   = PREP;
                        is_div_d  = op[1];
                        dz_d      = op[1] && srcb == '0;
                        dz_prev_d = divzero_q;
                        divzero_d = 1'b0;
                        a_raw_d   = srca;
`ifdef MULDIV_SIGNED_EN
                        ma_d   = sa ? -srca : srca;
                        mb_d   = sb ? -srcb : srcb;
                        neg_d  = sa ^ sb;
                        rneg_d = sa;
`else
                        ma_d   = srca;
                        mb_d   = srcb;
`endif
                    end
                end
                PREP: begin
                    state_d = RUN;
                    acc_d   = '0;
                    mq_d    = is_div_q ? ma_q : mb_q;
                    cnt_d   = CW'(WIDTH - 1);
                end
                RUN: begin
                    if (is_div_q) begin
                        acc_d = {ge ? diff : rem_sh[WIDTH-1:0], {WIDTH{1'b0}}};
                        mq_d  = {mq_q[WIDTH-2:0], ge};
                    end else begin
                        acc_d = {mq_q[0] ? sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]},
                                 acc_q[WIDTH-1:1]};
                        mq_d  = mq_q >> 1;
                    end
                    if (cnt_q == '0) state_d = FIX;
                    else cnt_d = cnt_q - CW'(1);
                end
                FIX: begin
                    state_d   = IDLE;
                    hi_d      = res_hi;
                    lo_d      = res_lo;
                    done_d    = 1'b1;
                    divzero_d = dz_q;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            dz_prev_q <= 1'b0;
            a_raw_q   <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            mq_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            dz_prev_q <= dz_prev_d;
            a_raw_q   <= a_raw_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            mq_q      <= mq_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against an arithmetic model.
// Honours MULDIV_SIGNED_EN the same way the design does.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         kill = 1'b0;
    logic         wrhi = 1'b0;
    logic         wrlo = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, divzero;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srca(srca), .srcb(srcb), .kill(kill),
        .wrhi(wrhi), .wrlo(wrlo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .divzero(divzero)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from arithmetic
    function automatic void calc(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] h,
                                 output logic [W-1:0] l, output logic z);
        bit sgn;
        int sa, sb;
        longint sp;
        logic [63:0] up;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        sa = a;
        sb = b;
        z = 1'b0;
        if (!o[1]) begin
            if (sgn) begin
                sp = longint'(sa) * longint'(sb);
                up = sp;
            end else begin
                up = {32'b0, a} * {32'b0, b};
            end
            h = up[63:32];
            l = up[31:0];
        end else if (b == 0) begin
            h = a;
            l = '1;
            z = 1'b1;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                l = 32'h8000_0000;
                h = 0;
            end else begin
                l = sa / sb;
                h = sa % sb;
            end
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    logic         m_busy = 0, m_done = 0, m_dz = 0, r_dz = 0, saved_dz = 0;
    int           age = 0;

    task automatic model_step();
        logic [W-1:0] nh, nl;
        logic nb, nz;
        nh = m_hi;
        nl = m_lo;
        nb = m_busy;
        nz = m_dz;
        m_done = 1'b0;
        if (reset) begin
            nh = 0; nl = 0; nb = 0; nz = 0;
        end else begin
            if (wrhi) nh = wdata;
            if (wrlo) nl = wdata;
            if (m_busy) begin
                if (kill) begin
                    nb = 0;
                    nz = saved_dz;
                end else begin
                    age++;
                    if (age == W + 2) begin
                        nh = r_hi; nl = r_lo; nz = r_dz;
                        nb = 0;
                        m_done = 1'b1;
                    end
                end
            end else if (start && !kill) begin
                nb = 1;
                age = 0;
                saved_dz = m_dz;
                nz = 0;
                calc(op, srca, srcb, r_hi, r_lo, r_dz);
            end
        end
        m_hi = nh;
        m_lo = nl;
        m_busy = nb;
        m_dz = nz;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cmp_hi", hi, m_hi);
            check("cmp_lo", lo, m_lo);
            check("cmp_busy", busy, m_busy);
            check("cmp_done", done, m_done);
            check("cmp_divzero", divzero, m_dz);
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle
    task automatic run_op(input string nm, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic ez, input int poke_at);
        int n, nbusy;
        bit seen;
        start = 1; op = o; srca = a; srcb = b;
        @(negedge clk);
        start = 0;
        n = 1; nbusy = 0; seen = 0;
        check({nm, "_dzclr"}, divzero, 0);
        while (n < 60) begin
            if (busy) nbusy++;
            if (done) begin
                seen = 1;
                break;
            end
            if (n == poke_at) begin
                start = 1; op = 2'b11; srca = 32'h55; srcb = 0;
            end else begin
                start = 0;
            end
            @(negedge clk);
            n++;
        end
        start = 0;
        check({nm, "_seen"}, seen, 1);
        check({nm, "_lat"}, n, W + 3);
        check({nm, "_busycyc"}, nbusy, W + 2);
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
        check({nm, "_dz"}, divzero, ez);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nd;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", divzero, 0);
        reset = 0;
        @(negedge clk);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
`ifdef MULDIV_SIGNED_EN
        run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0);
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0, 32'h8000_0000, 0, 0);
`else
        run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5,
               32'h0000_0004, 32'hFFFF_FFF1, 0, 0);
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2,
               32'h0000_0001, 32'h7FFF_FFFC, 0, 0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 32'h0, 0, 0);
`endif
        run_op("divu_z", 2'b10, 32'd10, 32'd0,
               32'h0000_000A, 32'hFFFF_FFFF, 1, 0);
        run_op("multu_b2b", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);

        // mthi/mtlo preload, then an operation killed in RUN
        wrhi = 1; wdata = 32'h11;
        @(negedge clk);
        wrhi = 0; wrlo = 1; wdata = 32'h22;
        @(negedge clk);
        wrlo = 0;
        check("pre_hi", hi, 32'h11);
        check("pre_lo", lo, 32'h22);
        start = 1; op = 2'b00; srca = 32'd7; srcb = 32'd9;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        kill = 1;
        @(negedge clk);
        kill = 0;
        check("kill_busy", busy, 0);
        check("kill_hi", hi, 32'h11);
        check("kill_lo", lo, 32'h22);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("kill_nodone", nd, 0);

        run_op("restart_ign", 2'b00, 32'h1234, 32'h5678,
               32'h0, 32'h0626_0060, 0, 10);

        // Reset in the middle of RUN
        start = 1; op = 2'b00; srca = 32'hFFFF; srcb = 32'hFFFF;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("rrun_hi", hi, 0);
        check("rrun_lo", lo, 0);
        check("rrun_busy", busy, 0);
        check("rrun_done", done, 0);
        check("rrun_dz", divzero, 0);
        reset = 0;
        @(negedge clk);

        for (int c = 0; c < 4000; c++) begin
            start = !m_busy && ($urandom_range(0, 2) == 0);
            kill  = ($urandom_range(0, 199) == 0);
            wrhi  = ($urandom_range(0, 24) == 0);
            wrlo  = ($urandom_range(0, 24) == 0);
            wdata = $urandom;
            op    = 2'($urandom_range(0, 3));
            srca  = rand_opnd();
            srcb  = rand_opnd();
            @(negedge clk);
        end
        start = 0; kill = 0; wrhi = 0; wrlo = 0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
